bus_region_decoder: RTL and testbench
=====================================

Name: bus_region_decoder

Overview:
- Parametrised, registered successor to the combinational ROM/RAM address decoder.
- Decodes a bus request against N base/mask regions with fixed priority and drives a registered one-hot region select.
- Inserts per-region wait states, then pulses a ready strobe. Unmapped accesses raise an error pulse.
- Sits between the CPU bus master and the memory/peripheral slaves.

Parameters:
- ADDR_W, 13, address width in bits.
- N_REGION, 2, number of decoded regions (1..8).
- REGION_BASE, {13'h0000, 13'h1800}, packed N_REGION*ADDR_W; region i occupies bits [i*ADDR_W +: ADDR_W].
- REGION_MASK, {13'h0000, 13'h1800}, packed N_REGION*ADDR_W; region i hits when (addr & MASK_i) == BASE_i.
- WAIT_CYCLES, {4'd0, 4'd1}, packed N_REGION*4; wait states per region (0..15).
- REGION_RO, 2'b10, per-region read-only flag; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req  in  1  access request; sampled only in IDLE
- addr  in  ADDR_W  access address; sampled with req
- we  in  1  write enable; sampled with req
- sel  out  N_REGION  registered one-hot region select; bit i is region i (default: bit0 RAM 1800h-1FFFh, bit1 ROM 0000h-17FFh)
- rdy  out  1  one-cycle access-complete strobe
- err  out  1  one-cycle error strobe (unmapped, or protected write)
- busy  out  1  high while an access is in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, sel=0, rdy=0, err=0, busy=0, wait counter=0.
- Priority: lowest hitting region index wins. With the defaults, region0 (RAM) is tested before region1, whose mask is all-zero and so catches everything else. This reproduces the legacy map.
- FSM states: IDLE, WAIT, ACK, ERR.
- IDLE:
  - If req=1, decode addr/we combinationally and register the result.
  - Hit on region k with WAIT_CYCLES_k=0 -> ACK.
  - Hit with WAIT_CYCLES_k=W>0 -> WAIT, counter loaded with W-1.
  - No hit -> ERR.
  - If req=0, stay in IDLE.
- WAIT: counter decrements each cycle. At count 0 -> ACK.
- ACK: rdy=1 for exactly this cycle, then -> IDLE.
- ERR: err=1 for exactly this cycle, sel=0, then -> IDLE.
- Timing, with req accepted in cycle 0:
  - sel=onehot(k) and busy=1 from cycle 1 through the rdy cycle inclusive. Both drop to 0 the cycle after.
  - rdy occurs in cycle 1+W.
  - Error case: err and busy high in cycle 1 only; sel stays 0.
- req while not in IDLE: ignored and not queued. The master must re-assert it. The earliest next acceptance is the cycle after rdy/err.
- addr/we are latched at acceptance; changes during WAIT/ACK have no effect.
- sel is never multi-hot, and it is 0 whenever rdy/err are 0 and busy=0.
- Reset mid-access: on the cycle after rst=1, all outputs are 0 and the FSM is in IDLE. No rdy/err is emitted for the aborted access.
- rst has priority over req in the same cycle.

Optional Feature:
- Macro: BUS_REGION_DECODER_WPROT_EN.
- When defined: a request with we=1 that hits a region whose REGION_RO bit is 1 goes to ERR. sel stays 0 and no wait states are counted. Reads to that region behave normally.
- When undefined: REGION_RO is ignored and writes decode exactly like reads.

Test Plan:
- Default params, req addr=13'h1800 we=0 at cycle 0 -> sel=2'b01 and busy=1 in cycles 1-2; rdy=1 in cycle 2 only; sel=0 and busy=0 in cycle 3.
- req addr=13'h0123 -> sel=2'b10 and rdy=1 in cycle 1; next req accepted in cycle 2 gives rdy in cycle 3 (back-to-back).
- Boundaries: addr=13'h17FF -> sel=2'b10; 13'h1800 -> sel=2'b01; 13'h1FFF -> sel=2'b01.
- N_REGION=1, base/mask 13'h1800/13'h1800, req addr=13'h0000 -> err=1 and busy=1 in cycle 1, sel=0, no rdy.
- RAM access with req held high and addr changed to 13'h0000 in cycle 1 -> ignored, sel stays 2'b01. Separate run with rst=1 in cycle 1 -> cycle 2 all outputs 0, no rdy ever.
- With BUS_REGION_DECODER_WPROT_EN defined: write addr=13'h0100 -> err in cycle 1, sel=0. Read addr=13'h0100 -> sel=2'b10 and rdy in cycle 1.

Source files
------------

// File: rtl/bus_region_decoder.sv
// Registered base/mask region decoder with per-region wait states, ready and error strobes.
// Optional write protection of read-only regions: define BUS_REGION_DECODER_WPROT_EN.
module bus_region_decoder #(
   parameter int ADDR_W   = 13,
   parameter int N_REGION = 2,
   parameter logic [N_REGION*ADDR_W-1:0] REGION_BASE = {13'h0000, 13'h1800},
   parameter logic [N_REGION*ADDR_W-1:0] REGION_MASK = {13'h0000, 13'h1800},
   parameter logic [N_REGION*4-1:0]      WAIT_CYCLES = {4'd0, 4'd1},
   parameter logic [N_REGION-1:0]        REGION_RO   = 2'b10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic [ADDR_W-1:0]   addr,
   input  logic                we,
   output logic [N_REGION-1:0] sel,
   output logic                rdy,
   output logic                err,
   output logic                busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   logic [1:0]          state_reg, state_next;
   logic [3:0]          cnt_reg, cnt_next;
   logic [N_REGION-1:0] sel_reg, sel_next;
   logic                rdy_reg, rdy_next;
   logic                err_reg, err_next;
   logic                busy_reg, busy_next;

   logic [N_REGION-1:0] hit;
   logic [N_REGION-1:0] win;
   logic [3:0]          wait_sel;
   logic                prot_err;

   generate
      for (genvar gi = 0; gi < N_REGION; gi++) begin : g_hit
         assign hit[gi] = ((addr & REGION_MASK[gi*ADDR_W +: ADDR_W])
                           == REGION_BASE[gi*ADDR_W +: ADDR_W]);
      end
   endgenerate

   // Isolating the lowest set bit gives fixed priority to the lowest region index.
   assign win = hit & (~hit + N_REGION'(1));

   always_comb begin
      wait_sel = 4'd0;
      for (int i = 0; i < N_REGION; i++) begin
         if (win[i]) begin
            wait_sel = wait_sel | WAIT_CYCLES[i*4 +: 4];
         end
      end
   end

`ifdef BUS_REGION_DECODER_WPROT_EN
   assign prot_err = we & (|(win & REGION_RO));
`else
   logic unused_wprot;
   assign unused_wprot = we;
   assign prot_err     = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sel_next   = sel_reg;
      busy_next  = busy_reg;
      rdy_next   = 1'b0;
      err_next   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (req) begin
               busy_next = 1'b1;
               if ((win == '0) || prot_err) begin
                  state_next = S_ERR;
                  err_next   = 1'b1;
                  sel_next   = '0;
               end else begin
                  sel_next = win;
                  if (wait_sel == 4'd0) begin
                     state_next = S_ACK;
                     rdy_next   = 1'b1;
                  end else begin
                     state_next = S_WAIT;
                     cnt_next   = wait_sel - 4'd1;
                  end
               end
            end
         end
         S_WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = S_ACK;
               rdy_next   = 1'b1;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         default: begin
            // ACK and ERR both last one cycle and release the bus.
            state_next = S_IDLE;
            cnt_next   = 4'd0;
            sel_next   = '0;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= 4'd0;
         sel_reg   <= '0;
         rdy_reg   <= 1'b0;
         err_reg   <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         sel_reg   <= sel_next;
         rdy_reg   <= rdy_next;
         err_reg   <= err_next;
         busy_reg  <= busy_next;
      end
   end

   assign sel  = sel_reg;
   assign rdy  = rdy_reg;
   assign err  = err_reg;
   assign busy = busy_reg;

endmodule

// File: tb/tb_bus_region_decoder.sv
// Self-checking bench for bus_region_decoder: default map plus a single-region instance.
module tb_bus_region_decoder;

   localparam logic [12:0] M_BASE [2] = '{13'h1800, 13'h0000};
   localparam logic [12:0] M_MASK [2] = '{13'h1800, 13'h0000};
   localparam int          M_WAIT [2] = '{1, 0};
   localparam bit          M_RO   [2] = '{1'b0, 1'b1};

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we;
   logic [12:0] addr;
   logic [1:0]  sel;
   logic        rdy, err, busy;

   logic        req1, we1;
   logic [12:0] addr1;
   logic [0:0]  sel1;
   logic        rdy1, err1, busy1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_region_decoder dut (
      .clk(clk), .rst(rst), .req(req), .addr(addr), .we(we),
      .sel(sel), .rdy(rdy), .err(err), .busy(busy)
   );

   bus_region_decoder #(
      .ADDR_W(13), .N_REGION(1),
      .REGION_BASE(13'h1800), .REGION_MASK(13'h1800),
      .WAIT_CYCLES(4'd0), .REGION_RO(1'b0)
   ) dut1 (
      .clk(clk), .rst(rst), .req(req1), .addr(addr1), .we(we1),
      .sel(sel1), .rdy(rdy1), .err(err1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [1:0] esel, input logic erdy,
                           input logic eerr, input logic ebusy);
      chk({tag, ".sel"}, 16'(sel), 16'(esel));
      chk({tag, ".rdy"}, 16'(rdy), 16'(erdy));
      chk({tag, ".err"}, 16'(err), 16'(eerr));
      chk({tag, ".busy"}, 16'(busy), 16'(ebusy));
   endtask

   // Reference: first region whose mask rule matches; protected writes become errors.
   function automatic int exp_region(input logic [12:0] a, input logic w);
      int k = -1;
      for (int i = 0; i < 2; i++) begin
         if (k < 0 && ((a & M_MASK[i]) == M_BASE[i])) k = i;
      end
`ifdef BUS_REGION_DECODER_WPROT_EN
      if (k >= 0 && w && M_RO[k]) k = -1;
`else
      if (w && 1'b0) k = -1;
`endif
      return k;
   endfunction

   // Called at a falling edge; req is sampled on the following rising edge (cycle 0).
   task automatic access(input logic [12:0] a, input logic w, input bit hold, input string tag);
      int         k;
      int         wt;
      logic [1:0] oh;
      k  = exp_region(a, w);
      wt = (k >= 0) ? M_WAIT[k] : 0;
      oh = (k >= 0) ? 2'(1 << k) : 2'b00;
      $display("txn %s addr=%h we=%b expect_region=%0d waits=%0d", tag, a, w, k, wt);
      req = 1'b1; addr = a; we = w;
      if (k < 0) begin
         @(negedge clk);
         req = 1'b0;
         chk_outs({tag, ".c1err"}, 2'b00, 1'b0, 1'b1, 1'b1);
      end else begin
         for (int c = 1; c <= 1 + wt; c++) begin
            @(negedge clk);
            if (hold) addr = 13'h0000;
            else req = 1'b0;
            chk_outs($sformatf("%s.c%0d", tag, c), oh, (c == 1 + wt), 1'b0, 1'b1);
         end
      end
      @(negedge clk);
      req = 1'b0;
      chk_outs({tag, ".idle"}, 2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [12:0] ra;
      logic        rw;
      rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0;
      req1 = 1'b0; addr1 = '0; we1 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_outs("reset", 2'b00, 1'b0, 1'b0, 1'b0);
      chk("reset.sel1", 16'(sel1), 16'd0);

      access(13'h1800, 1'b0, 1'b0, "ram_1800");
      access(13'h0123, 1'b0, 1'b0, "rom_0123");
      access(13'h0456, 1'b0, 1'b0, "rom_b2b");
      access(13'h17FF, 1'b0, 1'b0, "bnd_17ff");
      access(13'h1800, 1'b1, 1'b0, "bnd_1800w");
      access(13'h1FFF, 1'b0, 1'b0, "bnd_1fff");
      access(13'h1900, 1'b0, 1'b1, "ram_hold");
      access(13'h0100, 1'b1, 1'b0, "wr_0100");
      access(13'h0100, 1'b0, 1'b0, "rd_0100");

      // Reset during the RAM wait state aborts the access silently.
      $display("txn rst_mid addr=1a00 we=0");
      req = 1'b1; addr = 13'h1A00; we = 1'b0;
      @(negedge clk);
      req = 1'b0;
      chk_outs("rst_mid.c1", 2'b01, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_outs("rst_mid.c2", 2'b00, 1'b0, 1'b0, 1'b0);
      for (int c = 3; c < 7; c++) begin
         @(negedge clk);
         chk_outs($sformatf("rst_mid.c%0d", c), 2'b00, 1'b0, 1'b0, 1'b0);
      end

      // Single-region instance: unmapped access errors, mapped access acks at once.
      $display("txn n1_unmapped addr=0000");
      req1 = 1'b1; addr1 = 13'h0000;
      @(negedge clk);
      req1 = 1'b0;
      chk("n1.c1.err", 16'(err1), 16'd1);
      chk("n1.c1.busy", 16'(busy1), 16'd1);
      chk("n1.c1.sel", 16'(sel1), 16'd0);
      chk("n1.c1.rdy", 16'(rdy1), 16'd0);
      @(negedge clk);
      chk("n1.c2.err", 16'(err1), 16'd0);
      chk("n1.c2.busy", 16'(busy1), 16'd0);
      chk("n1.c2.rdy", 16'(rdy1), 16'd0);
      $display("txn n1_mapped addr=1800");
      req1 = 1'b1; addr1 = 13'h1800;
      @(negedge clk);
      req1 = 1'b0;
      chk("n1m.c1.rdy", 16'(rdy1), 16'd1);
      chk("n1m.c1.sel", 16'(sel1), 16'd1);
      chk("n1m.c1.err", 16'(err1), 16'd0);
      @(negedge clk);
      chk("n1m.c2.busy", 16'(busy1), 16'd0);

      for (int n = 0; n < 40; n++) begin
         ra = 13'($urandom);
         rw = 1'($urandom_range(0, 1));
         access(ra, rw, 1'b0, $sformatf("rnd%0d", n));
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk_outs("rnd.gap", 2'b00, 1'b0, 1'b0, 1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
